// File: rtl/update_scheduler.sv
// Frame sequencer for the Pong datapath: paddles, ball, then collision phases
// per video frame, plus serve hold, ball speed, scoring and game-over tracking.
module update_scheduler #(
  parameter int SERVE_DELAY   = 60,
  parameter int START_SPEED   = 2,
  parameter int MAX_SPEED     = 7,
  parameter int HITS_PER_STEP = 4,
  parameter int WIN_SCORE     = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic       frame_tick,
  input  logic       phase_done,
  input  logic       hit_paddle,
  input  logic       hit_goal,
  input  logic       goal_side,
  output logic       upd_paddles,
  output logic       upd_ball,
  output logic       chk_collide,
  output logic       serve,
  output logic [2:0] ball_speed,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       game_over,
  output logic       overrun
);
  localparam int HW = $clog2(HITS_PER_STEP + 1);
  localparam logic [7:0]    HOLD_INIT = 8'(SERVE_DELAY);
  localparam logic [2:0]    SPD_INIT  = 3'(START_SPEED);
  localparam logic [2:0]    SPD_MAX   = 3'(MAX_SPEED);
  localparam logic [HW-1:0] HITS_STEP = HW'(HITS_PER_STEP);
  localparam logic [3:0]    WIN       = 4'(WIN_SCORE);

  typedef enum logic [2:0] {IDLE, PADDLES, BALL, COLLIDE, OVER} state_t;

  state_t        state;
  logic [7:0]    hold;
  logic [HW-1:0] hits;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      upd_paddles <= 1'b0;
      upd_ball    <= 1'b0;
      chk_collide <= 1'b0;
      serve       <= 1'b0;
      ball_speed  <= SPD_INIT;
      score_left  <= 4'd0;
      score_right <= 4'd0;
      game_over   <= 1'b0;
      overrun     <= 1'b0;
      hold        <= HOLD_INIT;
      hits        <= '0;
    end else begin
      serve <= 1'b0;
      // A tick while a frame is still being sequenced means the datapath is too slow.
      if (frame_tick && state != IDLE && state != OVER) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (frame_tick && run) begin
            state       <= PADDLES;
            upd_paddles <= 1'b1;
          end
        end
        PADDLES: begin
          if (phase_done) begin
            upd_paddles <= 1'b0;
            if (hold != 8'd0) begin
              hold  <= hold - 8'd1;
              serve <= (hold == 8'd1);
              state <= IDLE;
            end else begin
              upd_ball <= 1'b1;
              state    <= BALL;
            end
          end
        end
        BALL: begin
          if (phase_done) begin
            upd_ball    <= 1'b0;
            chk_collide <= 1'b1;
            state       <= COLLIDE;
          end
        end
        COLLIDE: begin
          if (phase_done) begin
            chk_collide <= 1'b0;
            state       <= IDLE;
            if (hit_goal) begin
              ball_speed <= SPD_INIT;
              hits       <= '0;
              hold       <= HOLD_INIT;
              if (goal_side) begin
                score_left <= score_left + 4'd1;
                if (score_left + 4'd1 == WIN) begin
                  state     <= OVER;
                  game_over <= 1'b1;
                end
              end else begin
                score_right <= score_right + 4'd1;
                if (score_right + 4'd1 == WIN) begin
                  state     <= OVER;
                  game_over <= 1'b1;
                end
              end
            end else if (hit_paddle) begin
              if (hits == HITS_STEP - 1'b1) begin
                hits       <= '0;
                ball_speed <= (ball_speed >= SPD_MAX) ? SPD_MAX : ball_speed + 3'd1;
              end else begin
                hits <= hits + 1'b1;
              end
            end
          end
        end
        OVER: game_over <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_update_scheduler.sv
// Bench for update_scheduler: two parameterisations driven frame by frame and
// compared against a frame-level model of scoring, speed and serve hold.
module tb_update_scheduler;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic run[2], frame_tick[2], phase_done[2], hit_paddle[2], hit_goal[2], goal_side[2];
  logic upd_paddles[2], upd_ball[2], chk_collide[2], serve[2], game_over[2], overrun[2];
  logic [2:0] ball_speed[2];
  logic [3:0] score_left[2], score_right[2];

  int total = 0;
  int bad = 0;

  update_scheduler #(.SERVE_DELAY(3)) dut_a (
    .clock(clock), .reset(reset), .run(run[0]), .frame_tick(frame_tick[0]),
    .phase_done(phase_done[0]), .hit_paddle(hit_paddle[0]), .hit_goal(hit_goal[0]),
    .goal_side(goal_side[0]), .upd_paddles(upd_paddles[0]), .upd_ball(upd_ball[0]),
    .chk_collide(chk_collide[0]), .serve(serve[0]), .ball_speed(ball_speed[0]),
    .score_left(score_left[0]), .score_right(score_right[0]), .game_over(game_over[0]),
    .overrun(overrun[0]));

  update_scheduler #(.SERVE_DELAY(2), .START_SPEED(6), .WIN_SCORE(2)) dut_b (
    .clock(clock), .reset(reset), .run(run[1]), .frame_tick(frame_tick[1]),
    .phase_done(phase_done[1]), .hit_paddle(hit_paddle[1]), .hit_goal(hit_goal[1]),
    .goal_side(goal_side[1]), .upd_paddles(upd_paddles[1]), .upd_ball(upd_ball[1]),
    .chk_collide(chk_collide[1]), .serve(serve[1]), .ball_speed(ball_speed[1]),
    .score_left(score_left[1]), .score_right(score_right[1]), .game_over(game_over[1]),
    .overrun(overrun[1]));

  // Frame-level model: one call per frame tick.
  localparam int MAXS = 7;
  localparam int HPS  = 4;
  int p_sd[2]  = '{3, 2};
  int p_ss[2]  = '{2, 6};
  int p_win[2] = '{9, 2};
  int m_hold[2], m_spd[2], m_hits[2], m_sl[2], m_sr[2];
  bit m_over[2], m_ovr[2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_hold[d] = p_sd[d]; m_spd[d] = p_ss[d]; m_hits[d] = 0;
      m_sl[d] = 0; m_sr[d] = 0; m_over[d] = 0; m_ovr[d] = 0;
    end
  endtask

  task automatic model_frame(input int d, input bit r, hp, hg, gs, xt,
                             output int seq, output int sv);
    seq = 0; sv = 0;
    if (m_over[d] || !r) return;
    if (m_hold[d] > 0) begin
      m_hold[d]--;
      seq = 1;
      sv = (m_hold[d] == 0) ? 1 : 0;
      return;
    end
    seq = 123;
    if (xt) m_ovr[d] = 1;
    if (hg) begin
      if (gs) m_sl[d]++; else m_sr[d]++;
      m_spd[d] = p_ss[d]; m_hits[d] = 0; m_hold[d] = p_sd[d];
      if (m_sl[d] == p_win[d] || m_sr[d] == p_win[d]) m_over[d] = 1;
    end else if (hp) begin
      m_hits[d]++;
      if (m_hits[d] == HPS) begin
        m_hits[d] = 0;
        m_spd[d] = (m_spd[d] + 1 > MAXS) ? MAXS : m_spd[d] + 1;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one frame; seq encodes observed strobes in order (1=paddles, 2=ball, 3=collide).
  task automatic dut_frame(input int d, input bit r, hp, hg, gs, input int dly,
                           input bit xt, dr, junk, output int seq, output int sv);
    int code;
    bit done;
    seq = 0; sv = 0; done = 0;
    @(negedge clock);
    run[d] = r; phase_done[d] = junk; hit_goal[d] = junk; hit_paddle[d] = junk;
    goal_side[d] = junk;
    @(negedge clock);
    phase_done[d] = 0; hit_goal[d] = 0; hit_paddle[d] = 0; frame_tick[d] = 1;
    @(negedge clock);
    frame_tick[d] = 0;
    for (int c = 0; c < 16 && !done; c++) begin
      if (!(upd_paddles[d] | upd_ball[d] | chk_collide[d])) done = 1;
      else begin
        code = upd_paddles[d] ? 1 : (upd_ball[d] ? 2 : 3);
        seq = seq * 10 + code;
        repeat (dly) @(negedge clock);
        phase_done[d] = 1;
        if (code == 3) begin
          hit_paddle[d] = hp; hit_goal[d] = hg; goal_side[d] = gs;
        end else begin
          hit_paddle[d] = junk; hit_goal[d] = junk;
        end
        if (code == 2 && xt) frame_tick[d] = 1;
        if (code == 2 && dr) run[d] = 0;
        @(negedge clock);
        phase_done[d] = 0; hit_paddle[d] = 0; hit_goal[d] = 0; frame_tick[d] = 0;
        sv += int'(serve[d]);
      end
    end
    check("frame_end", 32'(done), 1);
    @(negedge clock);
    sv += int'(serve[d]);
  endtask

  task automatic run_frame(input int d, input bit r, hp, hg, gs, input int dly,
                           input bit xt, dr, junk, output int seq, output int sv);
    int es, esv;
    dut_frame(d, r, hp, hg, gs, dly, xt, dr, junk, seq, sv);
    model_frame(d, r, hp, hg, gs, xt, es, esv);
    check($sformatf("seq%0d", d), seq, es);
    check($sformatf("serve%0d", d), sv, esv);
    check($sformatf("speed%0d", d), 32'(ball_speed[d]), m_spd[d]);
    check($sformatf("score_left%0d", d), 32'(score_left[d]), m_sl[d]);
    check($sformatf("score_right%0d", d), 32'(score_right[d]), m_sr[d]);
    check($sformatf("game_over%0d", d), 32'(game_over[d]), 32'(m_over[d]));
    check($sformatf("overrun%0d", d), 32'(overrun[d]), 32'(m_ovr[d]));
  endtask

  task automatic check_reset(input int d);
    check("rst_paddles", 32'(upd_paddles[d]), 0);
    check("rst_ball", 32'(upd_ball[d]), 0);
    check("rst_collide", 32'(chk_collide[d]), 0);
    check("rst_serve", 32'(serve[d]), 0);
    check("rst_speed", 32'(ball_speed[d]), p_ss[d]);
    check("rst_scores", {score_left[d], score_right[d]}, 0);
    check("rst_over", 32'(game_over[d]), 0);
    check("rst_overrun", 32'(overrun[d]), 0);
  endtask

  typedef struct {
    bit hp, hg, gs;
    int seq, spd, sl, sr, sv;
  } vec_t;
  vec_t tbl[14];

  initial begin
    int s, sv, guard;
    int d;
    bit r, hp, hg, gs, xt, dr, jk;
    // Entries follow the initial serve on dut_a (speed 2, hits 0, hold 0).
    tbl[0]  = '{1, 0, 0, 123, 2, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 123, 2, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 123, 2, 0, 0, 0};
    tbl[3]  = '{1, 0, 0, 123, 3, 0, 0, 0};
    tbl[4]  = '{1, 0, 0, 123, 3, 0, 0, 0};
    tbl[5]  = '{1, 0, 0, 123, 3, 0, 0, 0};
    tbl[6]  = '{1, 0, 0, 123, 3, 0, 0, 0};
    tbl[7]  = '{1, 0, 0, 123, 4, 0, 0, 0};
    tbl[8]  = '{1, 1, 0, 123, 2, 0, 1, 0};
    tbl[9]  = '{0, 0, 0, 1,   2, 0, 1, 0};
    tbl[10] = '{0, 0, 0, 1,   2, 0, 1, 0};
    tbl[11] = '{0, 0, 0, 1,   2, 0, 1, 1};
    tbl[12] = '{0, 0, 0, 123, 2, 0, 1, 0};
    tbl[13] = '{0, 1, 1, 123, 2, 1, 1, 0};

    for (int i = 0; i < 2; i++) begin
      run[i] = 0; frame_tick[i] = 0; phase_done[i] = 0;
      hit_paddle[i] = 0; hit_goal[i] = 0; goal_side[i] = 0;
    end
    model_reset();
    repeat (3) @(negedge clock);
    check_reset(0);
    check_reset(1);
    reset = 1;

    // Initial serve on dut_a: three paddle-only frames, serve on the third.
    for (int i = 0; i < 4; i++) begin
      run_frame(0, 1, 0, 0, 0, 0, 0, 0, 0, s, sv);
      check("init_seq", s, (i < 3) ? 1 : 123);
      check("init_serve", sv, (i == 2) ? 1 : 0);
    end

    // Speed steps and goal handling, vectors above.
    for (int i = 0; i < 14; i++) begin
      run_frame(0, 1, tbl[i].hp, tbl[i].hg, tbl[i].gs, i % 3, 0, 0, 1, s, sv);
      check($sformatf("tbl%0d_seq", i), s, tbl[i].seq);
      check($sformatf("tbl%0d_serve", i), sv, tbl[i].sv);
      check($sformatf("tbl%0d_speed", i), 32'(ball_speed[0]), tbl[i].spd);
      check($sformatf("tbl%0d_sl", i), 32'(score_left[0]), tbl[i].sl);
      check($sformatf("tbl%0d_sr", i), 32'(score_right[0]), tbl[i].sr);
    end

    // dut_b: speed saturation from 6, then two left goals end the game.
    for (int i = 0; i < 2; i++) run_frame(1, 1, 0, 0, 0, 0, 0, 0, 0, s, sv);
    for (int i = 0; i < 8; i++) run_frame(1, 1, 1, 0, 0, 1, 0, 0, 0, s, sv);
    check("sat_speed", 32'(ball_speed[1]), 7);
    run_frame(1, 1, 0, 1, 1, 0, 0, 0, 0, s, sv);
    for (int i = 0; i < 2; i++) run_frame(1, 1, 0, 0, 0, 0, 0, 0, 0, s, sv);
    run_frame(1, 1, 0, 1, 1, 0, 0, 0, 0, s, sv);
    check("win_sl", 32'(score_left[1]), 2);
    check("win_over", 32'(game_over[1]), 1);
    for (int i = 0; i < 2; i++) begin
      run_frame(1, 1, 0, 0, 0, 0, 0, 0, 1, s, sv);
      check("over_seq", s, 0);
      check("over_overrun", 32'(overrun[1]), 0);
    end

    // Overrun during BALL, then run dropped mid-frame on dut_a.
    guard = 0;
    while (m_hold[0] > 0 && guard < 20) begin
      run_frame(0, 1, 0, 0, 0, 0, 0, 0, 0, s, sv); guard++;
    end
    run_frame(0, 1, 0, 0, 0, 1, 1, 0, 0, s, sv);
    check("ovr_seq", s, 123);
    check("ovr_flag", 32'(overrun[0]), 1);
    run_frame(0, 1, 0, 0, 0, 0, 0, 1, 0, s, sv);
    check("drop_seq", s, 123);
    run_frame(0, 0, 0, 0, 0, 0, 0, 0, 0, s, sv);
    check("norun_seq", s, 0);
    run_frame(0, 1, 0, 0, 0, 0, 0, 0, 0, s, sv);
    check("rerun_seq", s, 123);

    // Bring dut_a to 3/5, then reset while the collision strobe is up.
    guard = 0;
    while ((m_sl[0] != 3 || m_sr[0] != 5 || m_hold[0] != 0) && guard < 100) begin
      if (m_hold[0] > 0 || (m_sl[0] == 3 && m_sr[0] == 5))
        run_frame(0, 1, 0, 0, 0, 0, 0, 0, 0, s, sv);
      else
        run_frame(0, 1, 0, 1, (m_sl[0] < 3), 0, 0, 0, 0, s, sv);
      guard++;
    end
    @(negedge clock); frame_tick[0] = 1;
    @(negedge clock); frame_tick[0] = 0; phase_done[0] = 1;
    @(negedge clock);
    @(negedge clock); phase_done[0] = 0;
    check("mid_collide", 32'(chk_collide[0]), 1);
    check("mid_scores", {score_left[0], score_right[0]}, {4'd3, 4'd5});
    reset = 0;
    #1;
    check("arst_collide", 32'(chk_collide[0]), 0);
    check("arst_scores", {score_left[0], score_right[0]}, 0);
    check("arst_overrun", 32'(overrun[0]), 0);
    check("arst_speed", 32'(ball_speed[0]), 2);
    model_reset();
    @(negedge clock); reset = 1;

    // Randomized frames on both instances.
    for (int i = 0; i < 300; i++) begin
      d = $urandom_range(0, 1);
      if (m_over[d]) begin
        @(negedge clock); reset = 0;
        @(negedge clock); reset = 1;
        model_reset();
      end
      r  = ($urandom_range(0, 7) != 0);
      hp = $urandom_range(0, 1);
      hg = ($urandom_range(0, 5) == 0);
      gs = $urandom_range(0, 1);
      xt = ($urandom_range(0, 7) == 0);
      dr = ($urandom_range(0, 9) == 0);
      jk = $urandom_range(0, 1);
      run_frame(d, r, hp, hg, gs, $urandom_range(0, 2), xt, dr, jk, s, sv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/update_scheduler.md
# update_scheduler

Frame-level sequencer for the Pong game datapath. While the game is running, it turns each video-frame tick into an ordered series of update phases: paddles, ball, then collision. Each phase is a request/acknowledge handshake with the datapath. The block also owns the serve delay, ball speed, scores and game-over detection. It sits between the main FSM (`enable_game`, `reset`) and the paddle/ball/collision logic.

## Interface

Parameters:
- `SERVE_DELAY`, default 60: frames the ball is held after reset or after a goal (1..255).
- `START_SPEED`, default 2: ball speed after reset or after a goal.
- `MAX_SPEED`, default 7: saturation value of `ball_speed`.
- `HITS_PER_STEP`, default 4: paddle hits per +1 speed step.
- `WIN_SCORE`, default 9: score that ends the game (1..15).

Ports:
- `clock` in 1: single clock, all logic on posedge.
- `reset` in 1: asynchronous, active-low. Driven by the main FSM; low clears the whole match.
- `run` in 1: game enabled (main FSM `enable_game`). Sampled only at frame start.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `phase_done` in 1: datapath acknowledge for the active phase strobe.
- `hit_paddle` in 1: collision result. Valid with `phase_done` in COLLIDE.
- `hit_goal` in 1: ball left the field. Valid with `phase_done` in COLLIDE.
- `goal_side` in 1: 0 = ball exited left (right player scores), 1 = exited right (left player scores).
- `upd_paddles` out 1: paddle update request (level).
- `upd_ball` out 1: ball move request (level).
- `chk_collide` out 1: collision check request (level).
- `serve` out 1: one-cycle pulse; the datapath recentres the ball.
- `ball_speed` out 3: current ball speed.
- `score_left` out 4: left player score.
- `score_right` out 4: right player score.
- `game_over` out 1: a player reached `WIN_SCORE`.
- `overrun` out 1: sticky flag; a frame tick arrived while a frame was in progress.

## Operation

States: IDLE, PADDLES, BALL, COLLIDE, OVER. Phase strobes are registered and one-hot: `upd_paddles` in PADDLES, `upd_ball` in BALL, `chk_collide` in COLLIDE. All strobes are low in IDLE and OVER.

Internal registers:
- `hold`: 8-bit serve counter.
- `hits`: paddle-hit counter, wide enough for `HITS_PER_STEP`.

Transitions:
- **IDLE → PADDLES** on `frame_tick & run`.
- **IDLE, otherwise:** stay.
- **PADDLES, `phase_done`, `hold != 0`:**
  - Decrement `hold`.
  - If `hold` becomes 0, pulse `serve` for one cycle.
  - Go to IDLE. The ball does not move this frame.
- **PADDLES, `phase_done`, `hold == 0`:** go to BALL.
- **BALL, `phase_done`:** go to COLLIDE.
- **COLLIDE, `phase_done`, `hit_goal`:**
  - Increment the scoring player's score.
  - `ball_speed` ← `START_SPEED`, `hits` ← 0, `hold` ← `SERVE_DELAY`.
  - Go to OVER if the new score equals `WIN_SCORE`, else IDLE.
- **COLLIDE, `phase_done`, `!hit_goal & hit_paddle`:**
  - Increment `hits`.
  - When `hits` reaches `HITS_PER_STEP`: set `hits` ← 0 and `ball_speed` ← min(`ball_speed` + 1, `MAX_SPEED`).
  - Go to IDLE.
- **COLLIDE, `phase_done`, no hit:** go to IDLE.
- **OVER:** `game_over` = 1. Absorbing; left only via `reset`.

Boundary rules:
- `hit_goal` and `hit_paddle` both high: goal wins; `hits` and speed are untouched except for the goal reset.
- `phase_done` in IDLE or OVER, or with the strobe not yet asserted: ignored.
- `run` falling mid-frame: the current frame completes all its phases. No new frame starts until `run` is high at a `frame_tick`.
- `frame_tick` outside IDLE: ignored for sequencing and sets `overrun`. `overrun` is cleared only by `reset`.
- `frame_tick` in OVER: ignored and does not set `overrun`.
- Scores never exceed `WIN_SCORE`. No wrap occurs because OVER is entered at `WIN_SCORE`.
- `reset` asserted mid-phase: all state clears immediately; the strobe drops asynchronously.

## Timing

- Reset values:
  - State IDLE; all strobes 0; `serve` 0.
  - `ball_speed` = `START_SPEED`; scores 0; `hits` 0.
  - `hold` = `SERVE_DELAY`; `game_over` 0; `overrun` 0.
- `frame_tick` at cycle N → `upd_paddles` high at N+1.
- `phase_done` at cycle M → the current strobe is low at M+1 and the next strobe is high at M+1 (zero idle gap).
- Score, speed and `hold` updates are visible at M+1 after the COLLIDE acknowledge.
- `game_over` is high at M+1 after the winning goal.
- `serve` is high exactly at M+1 after the PADDLES acknowledge that brings `hold` to 0.
- Minimum frame with single-cycle acknowledges: 4 cycles (tick, 3 phases). A serve-hold frame takes 2 cycles.

## Test plan

1. **Initial serve.** Release reset, `run`=1, `phase_done` one cycle after each strobe, `SERVE_DELAY`=3. Required: the 3 ticks produce only `upd_paddles`; `serve` pulses after the 3rd; the 4th tick runs PADDLES→BALL→COLLIDE.
2. **Speed step.** Run 8 frames with `hit_paddle`=1 at COLLIDE. Required: `ball_speed` goes 2→3 after hit 4 and 3→4 after hit 8. With `START_SPEED`=6 and 8 hits: `ball_speed` saturates at 7.
3. **Goal, right player scores.** `hit_goal`=1, `goal_side`=0, `hit_paddle`=1 together. Required: `score_right`+1; `score_left` unchanged; `ball_speed`=2; the next 3 frames are paddle-only, then `serve`.
4. **Game over.** With `WIN_SCORE`=2, two left-side goals (`goal_side`=1). Required: `score_left`=2, `game_over`=1. Further `frame_tick` produce no strobes and do not set `overrun`.
5. **Overrun and `run` drop.** `frame_tick` during BALL. Required: `overrun`=1 and the sequence is unchanged. Drop `run` in BALL. Required: COLLIDE still completes, then no new PADDLES until `run`=1 at a tick.
6. **Reset mid-phase.** Assert `reset` low while `chk_collide`=1 with scores 3/5. Required: strobe, scores and `overrun` go to 0 asynchronously; `ball_speed`=2.
